// File: rtl/mod_counter_pro_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pro_pkg
// Shared types and helpers for the modulo-N counter slice.
//   cnt_mode_t  : count mode selector (up, down, bounce, one-shot)
//   cntWidth()  : bit width needed to hold values 0..n-1 (minimum 1 bit)
// ---------------------------------------------------------------------------
package mod_counter_pro_pkg;

  typedef enum logic [1:0] {
    CNT_UP      = 2'b00,
    CNT_DOWN    = 2'b01,
    CNT_UPDOWN  = 2'b10,
    CNT_ONESHOT = 2'b11
  } cnt_mode_t;

  // A divide-by-1 prescaler still needs a 1-bit register to stay well formed.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter_pro_if.sv
// ---------------------------------------------------------------------------
// mod_counter_pro_if
// Control/status bundle of the modulo-N counter.
//   en, load, load_val, mode : driven by the controlling block (master)
//   count, dir, tc, done     : registered counter status (slave)
//   at_max                   : combinational count == MODULO-1 (slave)
// ---------------------------------------------------------------------------
interface mod_counter_pro_if
  import mod_counter_pro_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  cnt_mode_t        mode;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             done;
  logic             at_max;

  modport master (
    output en, load, load_val, mode,
    input  count, dir, tc, done, at_max
  );

  modport slave (
    input  en, load, load_val, mode,
    output count, dir, tc, done, at_max
  );

endinterface

// File: rtl/mod_counter_pro_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Modulo-PRESCALE enable divider: step_o is high on every PRESCALE-th
// enabled cycle. The phase holds while en_i is low and returns to zero on
// clr_i.
//   clk     : clock, rising edge
//   rst     : synchronous, active-low reset
//   en_i    : advance the phase this cycle
//   clr_i   : restart the phase (takes priority over en_i)
//   step_o  : combinational step qualifier for the current cycle
// ---------------------------------------------------------------------------
module tick_prescaler
  import mod_counter_pro_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int PW = cntWidth(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // With PRESCALE == 1 the phase never leaves zero, so every enabled cycle
  // is a step.
  assign step_o = en_i && (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = step_o ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mod_counter_pro.sv
// ---------------------------------------------------------------------------
// mod_counter_pro
// Parametrised modulo-N counter with prescaler and four count modes
// (up, down, bounce, one-shot), synchronous saturating load, direction
// output, terminal-event pulse and sticky one-shot done flag.
//   clk     : clock, rising edge
//   rst     : synchronous, active-low reset
//   cnt_if  : slave side of mod_counter_pro_if
//             in : en, load, load_val, mode
//             out: count, dir, tc, done (registered), at_max (combinational)
// Parameters: WIDTH (count bits), MODULO (2..2**WIDTH), PRESCALE (>=1)
// ---------------------------------------------------------------------------
module mod_counter_pro
  import mod_counter_pro_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 256,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_counter_pro_if.slave     cnt_if
);

  generate
    if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
      $error("mod_counter_pro: MODULO must lie in 2..2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("mod_counter_pro: PRESCALE must be at least 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             step;
  logic [WIDTH-1:0] incVal;
  logic [WIDTH-1:0] decVal;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (cnt_if.en),
    .clr_i  (cnt_if.load),
    .step_o (step)
  );

  assign incVal = count_q + WIDTH'(1);
  assign decVal = count_q - WIDTH'(1);

  // Wraps and turnarounds compare against MAXV explicitly so that a
  // MODULO below 2**WIDTH never relies on natural overflow. In bounce mode
  // a count sitting on the far end (after a load or mode change) turns
  // around immediately instead of running past the range.
  always_comb begin
    count_d = count_q;
    dir_d   = (cnt_if.mode == CNT_UPDOWN) ? dir_q : 1'b1;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (cnt_if.load) begin
      count_d = (cnt_if.load_val > MAXV) ? MAXV : cnt_if.load_val;
      dir_d   = 1'b1;
      done_d  = 1'b0;
    end else if (step) begin
      case (cnt_if.mode)
        CNT_UP: begin
          if (count_q == MAXV) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = incVal;
          end
        end
        CNT_DOWN: begin
          if (count_q == '0) begin
            count_d = MAXV;
            tc_d    = 1'b1;
          end else begin
            count_d = decVal;
          end
        end
        CNT_UPDOWN: begin
          if (dir_q) begin
            if (count_q == MAXV) begin
              count_d = decVal;
              dir_d   = 1'b0;
            end else begin
              count_d = incVal;
              if (incVal == MAXV) begin
                dir_d = 1'b0;
                tc_d  = 1'b1;
              end
            end
          end else begin
            if (count_q == '0) begin
              count_d = incVal;
              dir_d   = 1'b1;
            end else begin
              count_d = decVal;
              if (decVal == '0) begin
                dir_d = 1'b1;
                tc_d  = 1'b1;
              end
            end
          end
        end
        CNT_ONESHOT: begin
          if (count_q == MAXV) begin
            done_d = 1'b1;
          end else begin
            count_d = incVal;
            if (incVal == MAXV) begin
              done_d = 1'b1;
              tc_d   = 1'b1;
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign cnt_if.count  = count_q;
  assign cnt_if.dir    = dir_q;
  assign cnt_if.tc     = tc_q;
  assign cnt_if.done   = done_q;
  assign cnt_if.at_max = (count_q == MAXV);

endmodule

// File: tb/tb_mod_counter_pro.sv
// ---------------------------------------------------------------------------
// tb_mod_counter_pro
// Directed bench for mod_counter_pro. Five instances cover the parameter
// sets needed: 0 = 256/P1, 1 = 10/P1, 2 = 4/P1, 3 = 5/P1, 4 = 256/P3.
// Each step drives one instance, queues the expected post-edge status and
// compares it once the edge has happened.
// ---------------------------------------------------------------------------
module tb_mod_counter_pro;
  import mod_counter_pro_pkg::*;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] count;
    logic       dir;
    logic       tc;
    logic       done;
    logic       atMax;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t expQ[$];

  logic [7:0] obsCount [5];
  logic       obsDir   [5];
  logic       obsTc    [5];
  logic       obsDone  [5];
  logic       obsAtMax [5];

  mod_counter_pro_if #(.WIDTH(8)) cif[5] ();

  mod_counter_pro #(.WIDTH(8), .MODULO(256), .PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .cnt_if(cif[0]));
  mod_counter_pro #(.WIDTH(8), .MODULO(10),  .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .cnt_if(cif[1]));
  mod_counter_pro #(.WIDTH(8), .MODULO(4),   .PRESCALE(1)) dut2 (.clk(clk), .rst(rst), .cnt_if(cif[2]));
  mod_counter_pro #(.WIDTH(8), .MODULO(5),   .PRESCALE(1)) dut3 (.clk(clk), .rst(rst), .cnt_if(cif[3]));
  mod_counter_pro #(.WIDTH(8), .MODULO(256), .PRESCALE(3)) dut4 (.clk(clk), .rst(rst), .cnt_if(cif[4]));

  for (genvar g = 0; g < 5; g++) begin : g_obs
    assign obsCount[g] = cif[g].count;
    assign obsDir[g]   = cif[g].dir;
    assign obsTc[g]    = cif[g].tc;
    assign obsDone[g]  = cif[g].done;
    assign obsAtMax[g] = cif[g].at_max;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modOf(input int sel);
    case (sel)
      1:       return 10;
      2:       return 4;
      3:       return 5;
      default: return 256;
    endcase
  endfunction

  task automatic driveInputs(input int sel, input logic e, input logic l,
                             input logic [7:0] lv, input logic [1:0] m);
    case (sel)
      0: begin cif[0].en = e; cif[0].load = l; cif[0].load_val = lv; cif[0].mode = cnt_mode_t'(m); end
      1: begin cif[1].en = e; cif[1].load = l; cif[1].load_val = lv; cif[1].mode = cnt_mode_t'(m); end
      2: begin cif[2].en = e; cif[2].load = l; cif[2].load_val = lv; cif[2].mode = cnt_mode_t'(m); end
      3: begin cif[3].en = e; cif[3].load = l; cif[3].load_val = lv; cif[3].mode = cnt_mode_t'(m); end
      default: begin cif[4].en = e; cif[4].load = l; cif[4].load_val = lv; cif[4].mode = cnt_mode_t'(m); end
    endcase
  endtask

  // Pops the oldest expectation and compares it against the addressed DUT.
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: observed empty queue, required one entry");
      return;
    end
    e = expQ.pop_front();
    checks++;
    assert (obsCount[e.sel] === e.count) else begin
      errors++;
      $error("FAIL %s count: observed %0d expected %0d", e.tag, obsCount[e.sel], e.count);
    end
    checks++;
    assert (obsDir[e.sel] === e.dir) else begin
      errors++;
      $error("FAIL %s dir: observed %b expected %b", e.tag, obsDir[e.sel], e.dir);
    end
    checks++;
    assert (obsTc[e.sel] === e.tc) else begin
      errors++;
      $error("FAIL %s tc: observed %b expected %b", e.tag, obsTc[e.sel], e.tc);
    end
    checks++;
    assert (obsDone[e.sel] === e.done) else begin
      errors++;
      $error("FAIL %s done: observed %b expected %b", e.tag, obsDone[e.sel], e.done);
    end
    checks++;
    assert (obsAtMax[e.sel] === e.atMax) else begin
      errors++;
      $error("FAIL %s at_max: observed %b expected %b", e.tag, obsAtMax[e.sel], e.atMax);
    end
  endtask

  // One clock of stimulus on instance sel, with the status expected after
  // the edge queued before the edge happens.
  task automatic applyStimulus(input string tag, input int sel, input logic e,
                               input logic l, input logic [7:0] lv, input logic [1:0] m,
                               input logic [7:0] expCount, input logic expDir,
                               input logic expTc, input logic expDone);
    exp_t x;
    @(negedge clk);
    driveInputs(sel, e, l, lv, m);
    x.tag   = tag;
    x.sel   = sel;
    x.count = expCount;
    x.dir   = expDir;
    x.tc    = expTc;
    x.done  = expDone;
    x.atMax = (int'(expCount) == modOf(sel) - 1);
    expQ.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int seqDown [5];
    int seqBnc  [7];
    int dirBnc  [7];
    int seqPre  [10];
    int enPre   [10];

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    driveInputs(0, 1'b0, 1'b0, 8'd0, 2'b00);
    driveInputs(1, 1'b0, 1'b0, 8'd0, 2'b01);
    driveInputs(2, 1'b0, 1'b0, 8'd0, 2'b10);
    driveInputs(3, 1'b0, 1'b0, 8'd0, 2'b11);
    driveInputs(4, 1'b0, 1'b0, 8'd0, 2'b00);

    $display("[TB] reset");
    for (int i = 0; i < 5; i++) begin
      applyStimulus("reset0", 0, 1'b1, 1'b0, 8'd0, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0);
    end
    for (int s = 1; s < 5; s++) begin
      applyStimulus("resetN", s, 1'b0, 1'b0, 8'd0, (s == 1) ? 2'b01 : (s == 2) ? 2'b10 : (s == 3) ? 2'b11 : 2'b00,
                    8'd0, 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;

    $display("[TB] up mode full wrap");
    for (int i = 1; i <= 256; i++) begin
      applyStimulus("up256", 0, 1'b1, 1'b0, 8'd0, 2'b00, 8'(i % 256), 1'b1, (i == 256), 1'b0);
    end
    driveInputs(0, 1'b0, 1'b0, 8'd0, 2'b00);

    $display("[TB] down mode mod 10");
    applyStimulus("downLoad", 1, 1'b0, 1'b1, 8'd3, 2'b01, 8'd3, 1'b1, 1'b0, 1'b0);
    seqDown = '{2, 1, 0, 9, 8};
    for (int i = 0; i < 5; i++) begin
      applyStimulus("down10", 1, 1'b1, 1'b0, 8'd0, 2'b01, 8'(seqDown[i]), 1'b1, (seqDown[i] == 9), 1'b0);
    end
    driveInputs(1, 1'b0, 1'b0, 8'd0, 2'b01);

    $display("[TB] bounce mode mod 4");
    seqBnc = '{1, 2, 3, 2, 1, 0, 1};
    dirBnc = '{1, 1, 0, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus("bounce4", 2, 1'b1, 1'b0, 8'd0, 2'b10, 8'(seqBnc[i]), dirBnc[i][0],
                    (i == 2) || (i == 5), 1'b0);
    end
    driveInputs(2, 1'b0, 1'b0, 8'd0, 2'b10);

    $display("[TB] one-shot mod 5");
    for (int i = 1; i <= 6; i++) begin
      applyStimulus("oneshot5", 3, 1'b1, 1'b0, 8'd0, 2'b11, 8'((i > 4) ? 4 : i), 1'b1, (i == 4), (i >= 4));
    end
    applyStimulus("oneshotLoad", 3, 1'b0, 1'b1, 8'd2, 2'b11, 8'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus("oneshotResume", 3, 1'b1, 1'b0, 8'd0, 2'b11, 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus("oneshotResume", 3, 1'b1, 1'b0, 8'd0, 2'b11, 8'd4, 1'b1, 1'b1, 1'b1);
    driveInputs(3, 1'b0, 1'b0, 8'd0, 2'b11);

    $display("[TB] prescale 3 with enable gap");
    enPre  = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    seqPre = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2};
    for (int i = 0; i < 10; i++) begin
      applyStimulus("prescale3", 4, enPre[i][0], 1'b0, 8'd0, 2'b00, 8'(seqPre[i]), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus("prescaleResume", 4, 1'b1, 1'b0, 8'd0, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0);
    driveInputs(4, 1'b0, 1'b0, 8'd0, 2'b00);

    $display("[TB] load saturation, load priority, mid-count reset");
    applyStimulus("loadSat", 1, 1'b0, 1'b1, 8'd12, 2'b00, 8'd9, 1'b1, 1'b0, 1'b0);
    applyStimulus("loadWins", 1, 1'b1, 1'b1, 8'd5, 2'b00, 8'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus("upAfterLoad", 1, 1'b1, 1'b0, 8'd0, 2'b00, 8'd6, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus("midReset", 1, 1'b1, 1'b0, 8'd0, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus("afterReset", 1, 1'b1, 1'b0, 8'd0, 2'b00, 8'd1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
